// File: rtl/pattern_tx_pkg.sv
// pattern_tx_pkg: FSM state encoding and default parameter values for the
// serial pattern transmitter.
package pattern_tx_pkg;

   localparam int unsigned PAT_W_DEF = 6;
   localparam int unsigned CNT_W_DEF = 4;
   localparam int unsigned GAP_W_DEF = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/pattern_tx_if.sv
// pattern_tx_if: request/stream bundle of the serial pattern transmitter.
// master = requester/stream consumer, slave = pattern_tx itself.
interface pattern_tx_if
   import pattern_tx_pkg::*;
#(
   parameter int unsigned PAT_W = PAT_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned GAP_W = GAP_W_DEF
) ();

   logic             start;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] repeat_n;
   logic [GAP_W-1:0] gap;
   logic             out;
   logic             out_valid;
   logic             busy;
   logic             done;

   modport master (
      output start, pattern, repeat_n, gap,
      input  out, out_valid, busy, done
   );

   modport slave (
      input  start, pattern, repeat_n, gap,
      output out, out_valid, busy, done
   );

endinterface

// File: rtl/pattern_tx_shreg.sv
// pattern_tx_shreg: loadable frame shift register plus bit counter.
// Optional macro PATTERN_TX_PARITY_EN appends an even-parity bit to the
// frame, so the frame becomes PAT_W+1 bits long.
// The register fills with zeros as it shifts, so after the last bit of a
// frame the msb reads 0 until the next load.
module pattern_tx_shreg #(
   parameter int unsigned PAT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [PAT_W-1:0] load_val,
   output logic             msb,
   output logic             last_bit
);

`ifdef PATTERN_TX_PARITY_EN
   localparam int unsigned FRAME_W = PAT_W + 1;
   logic [FRAME_W-1:0] frame_val;
   assign frame_val = {load_val, ^load_val};
`else
   localparam int unsigned FRAME_W = PAT_W;
   logic [FRAME_W-1:0] frame_val;
   assign frame_val = load_val;
`endif

   localparam int unsigned CNT_BITS = $clog2(FRAME_W);

   logic [FRAME_W-1:0]  sr;
   logic [CNT_BITS-1:0] cnt;

   assign msb      = sr[FRAME_W-1];
   assign last_bit = (cnt == CNT_BITS'(FRAME_W - 1));

   // Load restarts the frame; shift moves to the next bit, counter wraps at frame end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= frame_val;
         cnt <= '0;
      end else if (shift) begin
         sr  <= {sr[FRAME_W-2:0], 1'b0};
         cnt <= last_bit ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: serial pattern transmitter with start/busy/done handshake.
// Sends the latched pattern MSB-first repeat_n times with gap idle cycles
// between frames. Optional macro PATTERN_TX_PARITY_EN (in pattern_tx_shreg)
// adds a trailing even-parity bit to each frame.
module pattern_tx
   import pattern_tx_pkg::*;
#(
   parameter int unsigned PAT_W = PAT_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned GAP_W = GAP_W_DEF
) (
   input logic         clk,
   input logic         rst,
   pattern_tx_if.slave bus
);

   state_t           state, state_nxt;
   logic [PAT_W-1:0] pat_q;
   logic [GAP_W-1:0] gap_q;
   logic [CNT_W-1:0] rem_q, rem_nxt;
   logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
   logic             sr_load, sr_shift;
   logic [PAT_W-1:0] load_val;
   logic             msb, last_bit;
   logic             accept;

   assign accept = (state == IDLE) && bus.start;

   pattern_tx_shreg #(.PAT_W(PAT_W)) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .load     (sr_load),
      .shift    (sr_shift),
      .load_val (load_val),
      .msb      (msb),
      .last_bit (last_bit)
   );

   // The shift register msb is already a flop and self-clears between
   // frames, so it drives the serial output directly.
   assign bus.out = msb;

   // Next-state, counter updates and shift register control.
   always_comb begin
      state_nxt   = state;
      rem_nxt     = rem_q;
      gap_cnt_nxt = gap_cnt;
      sr_load     = 1'b0;
      sr_shift    = 1'b0;
      load_val    = pat_q;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               load_val = bus.pattern;
               rem_nxt  = bus.repeat_n;
               if (bus.repeat_n != '0) begin
                  sr_load   = 1'b1;
                  state_nxt = SHIFT;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         SHIFT: begin
            if (last_bit) begin
               rem_nxt = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  sr_shift  = 1'b1;
                  state_nxt = DONE;
               end else if (gap_q != '0) begin
                  sr_shift    = 1'b1;
                  gap_cnt_nxt = gap_q;
                  state_nxt   = GAP;
               end else begin
                  sr_load = 1'b1;
               end
            end else begin
               sr_shift = 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_W'(1)) begin
               sr_load   = 1'b1;
               state_nxt = SHIFT;
            end else begin
               gap_cnt_nxt = gap_cnt - GAP_W'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, latched request fields and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         rem_q         <= '0;
         gap_cnt       <= '0;
         pat_q         <= '0;
         gap_q         <= '0;
         bus.out_valid <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         state         <= state_nxt;
         rem_q         <= rem_nxt;
         gap_cnt       <= gap_cnt_nxt;
         bus.out_valid <= (state_nxt == SHIFT);
         bus.busy      <= (state_nxt != IDLE);
         bus.done      <= (state_nxt == DONE);
         if (accept) begin
            pat_q <= bus.pattern;
            gap_q <= bus.gap;
         end
      end
   end

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: directed self-checking bench for pattern_tx.
// Honours PATTERN_TX_PARITY_EN when the build defines it.
module tb_pattern_tx;

   localparam int unsigned PAT_W = 6;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned GAP_W = 3;
`ifdef PATTERN_TX_PARITY_EN
   localparam int FW = PAT_W + 1;
`else
   localparam int FW = PAT_W;
`endif

   logic clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;

   pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

   pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {out, out_valid, busy, done} in cycle c after an accept at the
   // end of cycle 0, from the frame/gap timeline of the request.
   function automatic logic [3:0] expv(int c, logic [PAT_W-1:0] p, int rep, int g);
      logic [FW-1:0] fr;
      int total, t, pos;
`ifdef PATTERN_TX_PARITY_EN
      fr = {p, ^p};
`else
      fr = p;
`endif
      total = (rep == 0) ? 1 : rep * FW + (rep - 1) * g + 1;
      if (c < 1 || c > total) return 4'b0000;
      if (c == total) return 4'b0011;
      t   = c - 1;
      pos = t % (FW + g);
      if (pos < FW) return {fr[FW-1-pos], 3'b110};
      return 4'b0010;
   endfunction

   function automatic int total_busy(int rep, int g);
      return (rep == 0) ? 1 : rep * FW + (rep - 1) * g + 1;
   endfunction

   // Present a request at the negedge of cycle 0; accepted at the next posedge.
   task automatic drive_start(logic [PAT_W-1:0] p, logic [CNT_W-1:0] r, logic [GAP_W-1:0] g);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.pattern  = p;
      bus.repeat_n = r;
      bus.gap      = g;
   endtask

   task automatic test_reset();
      logic [3:0] obs;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.pattern  = '0;
      bus.repeat_n = '0;
      bus.gap      = '0;
      repeat (3) @(negedge clk);
      obs = {bus.out, bus.out_valid, bus.busy, bus.done};
      total_cnt++;
      if (obs !== 4'b0000) $display("FAIL reset_state obs=%b exp=0000", obs);
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      obs = {bus.out, bus.out_valid, bus.busy, bus.done};
      total_cnt++;
      if (obs !== 4'b0000) $display("FAIL post_reset_idle obs=%b exp=0000", obs);
      else pass_cnt++;
   endtask

   task automatic test_single();
      logic [3:0]    obs, exp;
      logic [FW-1:0] bits, bits_exp;
      logic [5:0]    hist;
      int            hits, nbits;
`ifdef PATTERN_TX_PARITY_EN
      bits_exp = 7'b1101010;
`else
      bits_exp = 6'b110101;
`endif
      bits = '0; hist = '0; hits = 0; nbits = 0;
      drive_start(6'b110101, 4'd1, 3'd0);
      for (int c = 1; c <= FW + 2; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         obs = {bus.out, bus.out_valid, bus.busy, bus.done};
         exp = expv(c, 6'b110101, 1, 0);
         total_cnt++;
         if (obs !== exp) $display("FAIL single_c%0d obs=%b exp=%b", c, obs, exp);
         else pass_cnt++;
         if (bus.out_valid === 1'b1) begin
            bits = {bits[FW-2:0], bus.out};
            hist = {hist[4:0], bus.out};
            nbits++;
            if (nbits >= 6 && hist == 6'b110101) hits++;
         end
      end
      total_cnt++;
      if (bits !== bits_exp) $display("FAIL single_bits obs=%b exp=%b", bits, bits_exp);
      else pass_cnt++;
      total_cnt++;
      if (hits != 1) $display("FAIL single_detect obs=%0d exp=1", hits);
      else pass_cnt++;
   endtask

   task automatic test_repeat_gap();
      logic [3:0] obs, exp;
      int n;
      n = total_busy(3, 2);
      drive_start(6'b110101, 4'd3, 3'd2);
      for (int c = 1; c <= n + 1; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         obs = {bus.out, bus.out_valid, bus.busy, bus.done};
         exp = expv(c, 6'b110101, 3, 2);
         total_cnt++;
         if (obs !== exp) $display("FAIL repeat_gap_c%0d obs=%b exp=%b", c, obs, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_no_gap();
      logic [3:0]        obs, exp;
      logic [2*FW-1:0]   bits, bits_exp;
      int                n;
`ifdef PATTERN_TX_PARITY_EN
      bits_exp = 14'b11010101101010;
`else
      bits_exp = 12'b110101110101;
`endif
      bits = '0;
      n = total_busy(2, 0);
      drive_start(6'b110101, 4'd2, 3'd0);
      for (int c = 1; c <= n + 1; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         obs = {bus.out, bus.out_valid, bus.busy, bus.done};
         exp = expv(c, 6'b110101, 2, 0);
         total_cnt++;
         if (obs !== exp) $display("FAIL no_gap_c%0d obs=%b exp=%b", c, obs, exp);
         else pass_cnt++;
         if (bus.out_valid === 1'b1) bits = {bits[2*FW-2:0], bus.out};
      end
      total_cnt++;
      if (bits !== bits_exp) $display("FAIL no_gap_bits obs=%b exp=%b", bits, bits_exp);
      else pass_cnt++;
   endtask

   task automatic test_zero_repeat();
      logic [3:0] obs, exp;
      drive_start(6'b111111, 4'd0, 3'd3);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         obs = {bus.out, bus.out_valid, bus.busy, bus.done};
         exp = (c == 1) ? 4'b0011 : 4'b0000;
         total_cnt++;
         if (obs !== exp) $display("FAIL zero_repeat_c%0d obs=%b exp=%b", c, obs, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_max_repeat();
      logic [3:0] obs, exp;
      int n, errs;
      errs = 0;
      n = total_busy(15, 7);
      drive_start(6'b100110, 4'd15, 3'd7);
      for (int c = 1; c <= n + 1; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         obs = {bus.out, bus.out_valid, bus.busy, bus.done};
         exp = expv(c, 6'b100110, 15, 7);
         if (obs !== exp) begin
            if (errs < 4) $display("FAIL max_repeat_c%0d obs=%b exp=%b", c, obs, exp);
            errs++;
         end
      end
      total_cnt++;
      if (errs != 0) $display("FAIL max_repeat_errs obs=%0d exp=0", errs);
      else pass_cnt++;
   endtask

   task automatic test_ignore_busy();
      logic [3:0] obs, exp;
      drive_start(6'b110101, 4'd1, 3'd0);
      for (int c = 1; c <= FW + 2; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         if (c == 2) begin
            bus.start    = 1'b1;
            bus.pattern  = 6'b000000;
            bus.repeat_n = 4'd5;
            bus.gap      = 3'd3;
         end
         if (c == 3) bus.start = 1'b0;
         obs = {bus.out, bus.out_valid, bus.busy, bus.done};
         exp = expv(c, 6'b110101, 1, 0);
         total_cnt++;
         if (obs !== exp) $display("FAIL ignore_busy_c%0d obs=%b exp=%b", c, obs, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_mid_reset();
      logic [3:0] obs, exp;
      int dones;
      drive_start(6'b110101, 4'd2, 3'd1);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
      end
      #1 rst = 1'b1;
      #1;
      obs = {bus.out, bus.out_valid, bus.busy, bus.done};
      total_cnt++;
      if (obs !== 4'b0000) $display("FAIL mid_reset_async obs=%b exp=0000", obs);
      else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) dones++;
      end
      total_cnt++;
      if (dones != 0) $display("FAIL mid_reset_quiet obs=%0d exp=0", dones);
      else pass_cnt++;
      drive_start(6'b011011, 4'd1, 3'd0);
      for (int c = 1; c <= FW + 2; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         obs = {bus.out, bus.out_valid, bus.busy, bus.done};
         exp = expv(c, 6'b011011, 1, 0);
         total_cnt++;
         if (obs !== exp) $display("FAIL after_reset_c%0d obs=%b exp=%b", c, obs, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] obs, exp;
      int d;
      d = total_busy(1, 0);
      drive_start(6'b110101, 4'd1, 3'd0);
      for (int c = 1; c <= d + 1 + FW + 2; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         obs = {bus.out, bus.out_valid, bus.busy, bus.done};
         if (c <= d)          exp = expv(c, 6'b110101, 1, 0);
         else if (c == d + 1) exp = 4'b0000;
         else                 exp = expv(c - d - 1, 6'b101100, 1, 0);
         total_cnt++;
         if (obs !== exp) $display("FAIL back_to_back_c%0d obs=%b exp=%b", c, obs, exp);
         else pass_cnt++;
         if (c == d) begin
            bus.start    = 1'b1;
            bus.pattern  = 6'b101100;
            bus.repeat_n = 4'd1;
            bus.gap      = 3'd0;
         end
         if (c == d + 2) bus.start = 1'b0;
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_single();
      test_repeat_gap();
      test_no_gap();
      test_zero_repeat();
      test_max_repeat();
      test_ignore_busy();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/pattern_tx.md
Name: pattern_tx

Overview:
Serial pattern transmitter: on a start request it shifts a programmable PAT_W-bit pattern out MSB-first, one bit per clock, repeated repeat_n times with a programmable idle gap between repeats. It is the source side of the serial pattern detectors. It drives test/stimulus streams into them, for example 110101 for the 110101 detector, and gives other blocks a start/busy/done handshake.

Parameters:
PAT_W, 6, pattern length in bits (>=2)
CNT_W, 4, width of repeat count
GAP_W, 3, width of inter-repeat idle-gap count

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; accepted only in IDLE
pattern  in  PAT_W  pattern to send, MSB first; latched on accept
repeat_n  in  CNT_W  number of pattern transmissions; latched on accept
gap  in  GAP_W  idle cycles between repeats; latched on accept
out  out  1  serial data bit; 0 whenever out_valid=0
out_valid  out  1  out carries a pattern bit this cycle
busy  out  1  high from cycle after accept through DONE cycle
done  out  1  one-cycle pulse at end of request

Behaviour:
- Reset (any time, async): state=IDLE; out, out_valid, busy, done = 0; latched regs cleared. Reset mid-frame abandons the transfer with no done pulse.
- All outputs are registered. Only one clock domain.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE: out=0, out_valid=0, busy=0. If start=1, latch pattern/repeat_n/gap and load the shift register.
  - repeat_n!=0 -> SHIFT.
  - repeat_n==0 -> DONE; no bits sent.
- Latency: start accepted at edge k; first bit (pattern MSB) is on out with out_valid=1 in cycle k+1.
- SHIFT: out = current MSB of the shift register; the register shifts left each cycle. The bit counter runs 0..PAT_W-1.
  - After the last bit, decrement the remaining count.
  - Remaining>0 and gap>0 -> GAP.
  - Remaining>0 and gap==0 -> reload and stay in SHIFT. Frames are back-to-back with no bubble.
  - Remaining==0 -> DONE.
- GAP: out=0, out_valid=0, busy=1 for exactly gap cycles. Then reload the pattern and go to SHIFT.
- DONE: done=1, busy=1 for one cycle, out_valid=0; unconditionally -> IDLE.
  - start in the DONE cycle is ignored.
  - The earliest new accept is the following IDLE cycle.
- start while busy: ignored. Changes on pattern/repeat_n/gap while busy have no effect.
- Total busy cycles = repeat_n*PAT_W + (repeat_n-1)*gap + 1. The +1 is the DONE cycle. repeat_n=0 gives busy for 1 cycle.
- Counters never wrap during a request. repeat_n max = 2^CNT_W-1 is sent in full.

Optional Feature:
PATTERN_TX_PARITY_EN
- Defined: each frame is PAT_W data bits plus one trailing even-parity bit (XOR of latched pattern), with out_valid=1. Frame length is PAT_W+1 and the busy-cycle formula uses PAT_W+1.
- Undefined: frames are exactly PAT_W bits with no parity logic.

Decomposition:
- pattern_tx_pkg: state enum (IDLE, SHIFT, GAP, DONE) and default parameter constants.
- One natural sub-module: pattern_tx_shreg. It holds the loadable PAT_W shift register and bit counter, with load/shift inputs and msb/last_bit outputs. The FSM, repeat and gap counters stay in pattern_tx.

Test Plan:
1. pattern=6'b110101, repeat_n=1, gap=0, start pulse at cycle 0 -> out_valid cycles 1-6 with out=1,1,0,1,0,1; done=1 in cycle 7; busy cycles 1-7; a 110101 detector on out flags once.
2. pattern=6'b110101, repeat_n=3, gap=2 -> three frames at cycles 1-6, 9-14, 17-22; out=0/out_valid=0 in cycles 7-8 and 15-16; done in cycle 23.
3. repeat_n=2, gap=0 -> 12 consecutive valid bits (110101110101), no bubble; done in cycle 13.
4. repeat_n=0 -> busy and done only in cycle 1; out_valid never asserts.
5. start re-pulsed and pattern changed mid-frame -> ignored, original stream unchanged. rst asserted at cycle 3 -> all outputs 0 immediately, no done; new start after reset works normally.
6. With PATTERN_TX_PARITY_EN, pattern=6'b110101, repeat_n=1 -> 7 valid bits, 1101010 (parity=0); done in cycle 8.
